// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - scan-code constants, decoder states and scan-code to ASCII map
package kbd_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } kbd_state_t;

    // Set-2 make code to uppercase ASCII; anything unmapped returns 0.
    function automatic logic [7:0] sc_to_ascii(input logic [7:0] code);
        logic [7:0] a;
        case (code)
            8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
            8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
            8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
            8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
            8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
            8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver: synchronizer, edge detect, shift, frame check, timeout
module ps2_rx #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int SYNC_STAGES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       err_stb
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   data_s;
    logic [10:0]            shift;
    logic [3:0]             bit_cnt;
    logic [CW-1:0]          to_cnt;
    logic                   frame_done;
    logic                   to_err;
    logic                   frame_ok;

    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // Bring the idle-high PS/2 lines into the clk domain and keep one delayed copy of the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    // Shift bits in LSB first on each falling edge; abandon a frame that stalls too long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift      <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            frame_done <= 1'b0;
            to_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            to_err     <= 1'b0;
            if (fall) begin
                shift  <= {data_s, shift[10:1]};
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt == 4'd0) begin
                to_cnt <= '0;
            end else if (to_cnt == CW'(TIMEOUT_CYC - 1)) begin
                to_cnt  <= '0;
                bit_cnt <= '0;
                to_err  <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // shift[0]=start, [8:1]=data, [9]=odd parity, [10]=stop once a frame completes.
    assign frame_ok = ~shift[0] & shift[10] & (^shift[9:1]);
    assign rx_byte  = shift[8:1];
    assign byte_stb = frame_done & frame_ok;
    assign err_stb  = (frame_done & ~frame_ok) | to_err;

endmodule

// File: rtl/ps2_kbd_ascii.sv
// rtl/ps2_kbd_ascii.sv - PS/2 keyboard to held-key ASCII; KBD_PRESS_COUNT_EN adds press_cnt
module ps2_kbd_ascii
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000,
    parameter int SYNC_STAGES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] kbdata,
    output logic [7:0] scan_code,
    output logic       key_valid,
    output logic       frame_err
`ifdef KBD_PRESS_COUNT_EN
    ,
    output logic [9:0] press_cnt
`endif
);

    logic [7:0] rx_byte;
    logic       byte_stb;
    logic       err_stb;
    kbd_state_t state_q, state_d;
    logic [7:0] kb_d;
    logic [7:0] sc_d;
    logic       kv_d;
    logic [7:0] ascii;

    ps2_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .byte_stb (byte_stb),
        .err_stb  (err_stb)
    );

    // Decoder state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Prefix tracking plus make/break handling; last pressed key owns the outputs.
    always_comb begin
        state_d = state_q;
        kb_d    = kbdata;
        sc_d    = scan_code;
        kv_d    = 1'b0;
        ascii   = sc_to_ascii(rx_byte);
        if (byte_stb) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_byte == SC_BREAK) begin
                        state_d = S_BRK;
                    end else if (rx_byte == SC_EXT) begin
                        state_d = S_EXT;
                    end else if (ascii != 8'h00 && rx_byte != scan_code) begin
                        kb_d = ascii;
                        sc_d = rx_byte;
                        kv_d = 1'b1;
                    end
                end
                S_BRK: begin
                    if (rx_byte == scan_code) begin
                        kb_d = 8'h00;
                        sc_d = 8'h00;
                    end
                    state_d = S_IDLE;
                end
                S_EXT:     state_d = (rx_byte == SC_BREAK) ? S_EXT_BRK : S_IDLE;
                S_EXT_BRK: state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Output registers; frame_err follows the receiver error strobe by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbdata    <= 8'h00;
            scan_code <= 8'h00;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            kbdata    <= kb_d;
            scan_code <= sc_d;
            key_valid <= kv_d;
            frame_err <= err_stb;
        end
    end

`ifdef KBD_PRESS_COUNT_EN
    // Count accepted key presses, wrapping naturally at 1023.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    press_cnt <= 10'd0;
        else if (kv_d) press_cnt <= press_cnt + 10'd1;
    end
`endif

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// tb/tb_ps2_kbd_ascii.sv - table-driven bench for ps2_kbd_ascii
module tb_ps2_kbd_ascii;

    localparam int TO = 2000;
    localparam int H  = 15;

    typedef struct {
        logic [7:0] code;
        bit         bad;
        logic [7:0] kb;
        logic [7:0] sc;
        int         kv;
        int         er;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] kbdata;
    logic [7:0] scan_code;
    logic       key_valid;
    logic       frame_err;

    int   kv_cnt = 0;
    int   er_cnt = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   lat = -1;
    vec_t vecs[$];

    ps2_kbd_ascii #(.TIMEOUT_CYC(TO), .SYNC_STAGES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .kbdata    (kbdata),
        .scan_code (scan_code),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid) kv_cnt++;
        if (frame_err) er_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic void add(input logic [7:0] code, input bit bad, input logic [7:0] kb,
                                input logic [7:0] sc, input int kv, input int er);
        vec_t v;
        v.code = code; v.bad = bad; v.kb = kb; v.sc = sc; v.kv = kv; v.er = er;
        vecs.push_back(v);
    endfunction

    task automatic drive_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        for (int i = 1; i <= H; i++) begin
            @(negedge clk);
            if (lat < 0 && key_valid) lat = i;
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        lat = -1;
        for (int i = 0; i < nbits; i++) drive_bit(f[i]);
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    initial begin
        int kv0, er0;

        add(8'h1C, 0, 8'h41, 8'h1C, 1, 0);
        add(8'hF0, 0, 8'h41, 8'h1C, 0, 0);
        add(8'h1C, 0, 8'h00, 8'h00, 0, 0);
        add(8'h1C, 0, 8'h41, 8'h1C, 1, 0);
        for (int i = 0; i < 4; i++) add(8'h1C, 0, 8'h41, 8'h1C, 0, 0);
        add(8'hF0, 0, 8'h41, 8'h1C, 0, 0);
        add(8'h1C, 0, 8'h00, 8'h00, 0, 0);
        add(8'h1C, 0, 8'h41, 8'h1C, 1, 0);
        add(8'h16, 0, 8'h31, 8'h16, 1, 0);
        add(8'hF0, 0, 8'h31, 8'h16, 0, 0);
        add(8'h1C, 0, 8'h31, 8'h16, 0, 0);
        add(8'hF0, 0, 8'h31, 8'h16, 0, 0);
        add(8'h16, 0, 8'h00, 8'h00, 0, 0);
        add(8'h24, 1, 8'h00, 8'h00, 0, 1);
        add(8'h24, 0, 8'h45, 8'h24, 1, 0);
        add(8'hE0, 0, 8'h45, 8'h24, 0, 0);
        add(8'h75, 0, 8'h45, 8'h24, 0, 0);
        add(8'hE0, 0, 8'h45, 8'h24, 0, 0);
        add(8'hF0, 0, 8'h45, 8'h24, 0, 0);
        add(8'h75, 0, 8'h45, 8'h24, 0, 0);
        add(8'h2D, 0, 8'h52, 8'h2D, 1, 0);
        add(8'h45, 0, 8'h30, 8'h45, 1, 0);
        add(8'h76, 0, 8'h30, 8'h45, 0, 0);
        add(8'hF0, 0, 8'h30, 8'h45, 0, 0);
        add(8'h45, 0, 8'h00, 8'h00, 0, 0);
        add(8'h5A, 0, 8'h00, 8'h00, 0, 0);

        repeat (3) @(negedge clk);
        check("reset_kbdata", kbdata, 0);
        check("reset_scan_code", scan_code, 0);
        check("reset_key_valid", key_valid, 0);
        check("reset_frame_err", frame_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        foreach (vecs[i]) begin
            kv0 = kv_cnt;
            er0 = er_cnt;
            send_frame(vecs[i].code, vecs[i].bad, 11);
            repeat (10) @(negedge clk);
            check($sformatf("v%0d_kbdata", i), kbdata, vecs[i].kb);
            check($sformatf("v%0d_scan_code", i), scan_code, vecs[i].sc);
            check($sformatf("v%0d_key_valid_pulses", i), kv_cnt - kv0, vecs[i].kv);
            check($sformatf("v%0d_frame_err_pulses", i), er_cnt - er0, vecs[i].er);
            if (i == 0) check("make_latency_cycles", lat, 5);
        end

        er0 = er_cnt;
        send_frame(8'h2D, 0, 6);
        repeat (TO + 20) @(negedge clk);
        check("timeout_frame_err", er_cnt - er0, 1);
        check("timeout_kbdata", kbdata, 0);
        kv0 = kv_cnt;
        send_frame(8'h16, 0, 11);
        repeat (10) @(negedge clk);
        check("after_timeout_kbdata", kbdata, 8'h31);
        check("after_timeout_key_valid", kv_cnt - kv0, 1);

        send_frame(8'h1C, 0, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_kbdata", kbdata, 0);
        check("midreset_scan_code", scan_code, 0);
        check("midreset_key_valid", key_valid, 0);
        check("midreset_frame_err", frame_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        er0 = er_cnt;
        send_frame(8'h1C, 0, 11);
        repeat (10) @(negedge clk);
        check("after_reset_kbdata", kbdata, 8'h41);
        check("after_reset_frame_err", er_cnt - er0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
